clarke_sampler: RTL and testbench
=================================

# clarke_sampler

Front-end stage that feeds `kalman`. It accepts three-phase current and voltage samples in Q(N,Q) fixed point and box-car averages 2^AVG_LOG2 of them. It then computes the amplitude-invariant Clarke transform on one shared multiplier and presents `ialpham`, `ibetam`, `valpha` and `vbeta` as registered, held outputs with a one-cycle `out_valid` strobe.

## Interface
- `N`, 32, word width (signed two's complement).
- `Q`, 18, fractional bits.
- `AVG_LOG2`, 2, log2 of the number of samples averaged (legal range 0..4).

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  qualifies `ia`, `ib`, `ic`, `va`, `vb`, `vc` this cycle.
- `ia`, `ib`, `ic`  in  N each  phase currents, Q format.
- `va`, `vb`, `vc`  in  N each  phase voltages, Q format.
- `sample_ready`  out  1  high when a sample will be accepted.
- `ialpham`, `ibetam`, `valpha`, `vbeta`  out  N each  Clarke outputs, held between updates.
- `out_valid`  out  1  one-cycle strobe: outputs were updated this cycle.
- `overrun`  out  1  sticky: a sample was presented while `sample_ready` was low.

## Operation
- Constants:
  - C23 = round(2/3·2^Q), which is 174763 at Q=18.
  - CIS3 = round(2^Q/√3), which is 151349 at Q=18.
  - Both are derived from Q in elaboration.
- Accumulators: six signed registers, N+AVG_LOG2 bits each. Sample count `cnt` is AVG_LOG2 bits wide.
- The FSM has states ACC, PREP, MUL0, MUL1, MUL2, MUL3, DONE.
  - **ACC:** `sample_ready`=1.
    - On `sample_valid`, add the six inputs (sign-extended) to the accumulators and increment `cnt`.
    - When the accepted sample is number 2^AVG_LOG2, go to PREP and set `cnt` to 0.
  - **PREP:**
    - avg_x = acc_x >>> AVG_LOG2 (arithmetic shift, floor), truncated to N bits.
    - dai = avg_ia − (avg_ib + avg_ic)>>>1.
    - dbi = avg_ib − avg_ic.
    - dav and dbv are formed the same way from the voltages.
    - The intermediate sum is N+1 bits; dai, dbi, dav and dbv are N bits.
    - Clear all accumulators, then go to MUL0.
  - **MUL0..MUL3:** one shared product per cycle, into shadow registers:
    - MUL0: dai·C23 → ialpha.
    - MUL1: dbi·CIS3 → ibeta.
    - MUL2: dav·C23 → valpha.
    - MUL3: dbv·CIS3 → vbeta.
  - **DONE:** copy the shadow registers to the outputs, pulse `out_valid`, return to ACC.
- Multiply rule:
  - Full 2N-bit signed product, result = bits [N−1+Q:Q].
  - This truncates toward −∞, with no rounding and no saturation, matching the codebase `qmult` convention.
  - Inputs are limited so that |d|<2^(N−Q−2) and no overflow is possible.
- `sample_ready` = (state==ACC).
- In any state other than ACC, `sample_valid` discards the sample and sets `overrun`=1. `overrun` is cleared only by reset.
- Outputs hold their last value until the next DONE. The downstream `kalman` samples them at will.

## Timing
- Reset values:
  - Outputs: `ialpham`, `ibetam`, `valpha`, `vbeta` = 0; `out_valid` = 0; `overrun` = 0; `sample_ready` = 1 (state ACC).
  - Internal: accumulators = 0, `cnt` = 0, shadows = 0.
- Latency: the final sample is accepted at edge E. PREP executes at E+1 and MUL0..MUL3 at E+2..E+5. The outputs and `out_valid`=1 appear after edge E+6, and `out_valid` drops after E+7.
- `sample_ready` is low from after edge E until after edge E+6, i.e. for 6 cycles. The minimum sample period for zero overruns is 1 cycle while in ACC.
- Throughput: one output per 2^AVG_LOG2 + 6 cycles at maximum input rate.
- With AVG_LOG2=0, every accepted sample goes to PREP.
- Reset asserted in any state, including mid-MUL:
  - The effect is immediate.
  - The partial average and shadows are discarded.
  - No `out_valid` is produced for that batch.

## Test plan
- **Reset:** assert `reset`=0 with random inputs → all outputs 0, `out_valid`=0, `overrun`=0, `sample_ready`=1. Release, then 4 valid samples with all inputs 0 → `out_valid` 6 edges after the 4th sample, all outputs 0.
- **Alpha path:** 4 samples of ia=262144, ib=ic=−131072 (same values on va/vb/vc) → `ialpham`=`valpha`=262144; `ibetam`=`vbeta`=0.
- **Beta path:** 4 samples of ia=0, ib=131072, ic=−131072 → `ialpham`=0, `ibetam`=151349. Voltages with identical values give identical results.
- **Averaging and floor:**
  - ia = 4, 8, 12, 16 with ib=ic=0 → `ialpham`=6.
  - ia = −4, −8, −12, −16 → `ialpham`=−7.
- **Overrun:** hold `sample_valid`=1 continuously for 20 cycles with ia=262144, ib=ic=−131072 → samples during the 6 busy cycles are dropped, `overrun`=1 and stays 1. Every `out_valid` shows `ialpham`=262144. Strobes are spaced 10 cycles apart.
- **Reset mid-compute:** pull `reset` low during MUL2 → outputs 0 and no `out_valid`. After release, a fresh 4-sample batch produces correct results with no contamination from the aborted batch.

Source files
------------

// File: rtl/clarke_sampler_if.sv
// ============================================================================
//  clarke_sampler_if
//  Sample-in / Clarke-out bundle between the phase sampler and kalman.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface clarke_sampler_if #(
   parameter int N = 32
);
   logic                sample_valid;
   logic signed [N-1:0] ia;
   logic signed [N-1:0] ib;
   logic signed [N-1:0] ic;
   logic signed [N-1:0] va;
   logic signed [N-1:0] vb;
   logic signed [N-1:0] vc;
   logic                sample_ready;
   logic signed [N-1:0] ialpham;
   logic signed [N-1:0] ibetam;
   logic signed [N-1:0] valpha;
   logic signed [N-1:0] vbeta;
   logic                out_valid;
   logic                overrun;

   modport master (
      output sample_valid, ia, ib, ic, va, vb, vc,
      input  sample_ready, ialpham, ibetam, valpha, vbeta, out_valid, overrun
   );

   modport slave (
      input  sample_valid, ia, ib, ic, va, vb, vc,
      output sample_ready, ialpham, ibetam, valpha, vbeta, out_valid, overrun
   );
endinterface

`default_nettype wire

// File: rtl/clarke_sampler.sv
// ============================================================================
//  clarke_sampler
//  Box-car averages 2^AVG_LOG2 three-phase samples, then applies the
//  amplitude-invariant Clarke transform on one shared multiplier.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module clarke_sampler #(
   parameter int N        = 32,
   parameter int Q        = 18,
   parameter int AVG_LOG2 = 2
) (
   input  logic             clk,
   input  logic             reset,
   clarke_sampler_if.slave  bus
);

   function automatic longint calc_c23(input int q);
      return ((longint'(1) << (q + 1)) + 1) / 3;
   endfunction

   // Largest x with (x - 0.5) <= 2^q/sqrt(3), i.e. round-half-up, in integers.
   function automatic longint calc_cis3(input int q);
      longint lim;
      longint x;
      longint t;
      lim = longint'(4) << (2 * q);
      x   = 0;
      for (int b = q; b >= 0; b--) begin
         t = x | (longint'(1) << b);
         if (3 * (2 * t - 1) * (2 * t - 1) <= lim) x = t;
      end
      return x;
   endfunction

   localparam int                  NSAMP = 1 << AVG_LOG2;
   localparam int                  CW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int                  AW    = N + AVG_LOG2;
   localparam logic signed [N-1:0] C23   = N'(calc_c23(Q));
   localparam logic signed [N-1:0] CIS3  = N'(calc_cis3(Q));

   typedef enum logic [2:0] {
      ACC  = 3'd0,
      PREP = 3'd1,
      MUL0 = 3'd2,
      MUL1 = 3'd3,
      MUL2 = 3'd4,
      MUL3 = 3'd5,
      DONE = 3'd6
   } state_t;

   state_t state;
   state_t state_nxt;

   logic signed [N-1:0]   smp [6];
   logic signed [AW-1:0]  acc [6];
   logic signed [N-1:0]   avg [6];
   logic [CW-1:0]         cnt;
   logic                  last_smp;

   logic signed [N-1:0]   dai, dbi, dav, dbv;
   logic signed [N-1:0]   sh_ialpha, sh_ibeta, sh_valpha, sh_vbeta;
   logic signed [N-1:0]   ialpha_out, ibeta_out, valpha_out, vbeta_out;
   logic                  valid_out;
   logic                  overrun_flag;

   logic signed [N-1:0]   mul_a;
   logic signed [N-1:0]   mul_b;
   logic signed [2*N-1:0] prod;
   logic signed [N-1:0]   prod_q;

   // a - (b + c)/2 with the half-sum kept one bit wider to avoid overflow.
   function automatic logic signed [N-1:0] diff_alpha(
      input logic signed [N-1:0] a,
      input logic signed [N-1:0] b,
      input logic signed [N-1:0] c
   );
      logic signed [N:0] s;
      s = {b[N-1], b} + {c[N-1], c};
      s = s >>> 1;
      return a - $signed(s[N-1:0]);
   endfunction

   assign smp[0] = bus.ia;
   assign smp[1] = bus.ib;
   assign smp[2] = bus.ic;
   assign smp[3] = bus.va;
   assign smp[4] = bus.vb;
   assign smp[5] = bus.vc;

   always_comb begin
      for (int k = 0; k < 6; k++) begin
         avg[k] = N'(acc[k] >>> AVG_LOG2);
      end
   end

   assign last_smp = (cnt == CW'(NSAMP - 1));

   always_comb begin
      mul_a = dai;
      mul_b = C23;
      case (state)
         MUL1:    begin mul_a = dbi; mul_b = CIS3; end
         MUL2:    begin mul_a = dav; mul_b = C23;  end
         MUL3:    begin mul_a = dbv; mul_b = CIS3; end
         default: begin mul_a = dai; mul_b = C23;  end
      endcase
   end

   assign prod   = (2*N)'(mul_a) * (2*N)'(mul_b);
   assign prod_q = prod[N-1+Q:Q];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ACC;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACC:     if (bus.sample_valid && last_smp) state_nxt = PREP;
         PREP:    state_nxt = MUL0;
         MUL0:    state_nxt = MUL1;
         MUL1:    state_nxt = MUL2;
         MUL2:    state_nxt = MUL3;
         MUL3:    state_nxt = DONE;
         DONE:    state_nxt = ACC;
         default: state_nxt = ACC;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 6; k++) acc[k] <= '0;
         cnt          <= '0;
         dai          <= '0;
         dbi          <= '0;
         dav          <= '0;
         dbv          <= '0;
         sh_ialpha    <= '0;
         sh_ibeta     <= '0;
         sh_valpha    <= '0;
         sh_vbeta     <= '0;
         ialpha_out   <= '0;
         ibeta_out    <= '0;
         valpha_out   <= '0;
         vbeta_out    <= '0;
         valid_out    <= 1'b0;
         overrun_flag <= 1'b0;
      end else begin
         valid_out <= (state == DONE);
         if (bus.sample_valid && (state != ACC)) overrun_flag <= 1'b1;
         case (state)
            ACC: begin
               if (bus.sample_valid) begin
                  for (int k = 0; k < 6; k++) acc[k] <= acc[k] + AW'(smp[k]);
                  cnt <= last_smp ? '0 : cnt + 1'b1;
               end
            end
            PREP: begin
               dai <= diff_alpha(avg[0], avg[1], avg[2]);
               dbi <= avg[1] - avg[2];
               dav <= diff_alpha(avg[3], avg[4], avg[5]);
               dbv <= avg[4] - avg[5];
               for (int k = 0; k < 6; k++) acc[k] <= '0;
            end
            MUL0: sh_ialpha <= prod_q;
            MUL1: sh_ibeta  <= prod_q;
            MUL2: sh_valpha <= prod_q;
            MUL3: sh_vbeta  <= prod_q;
            DONE: begin
               ialpha_out <= sh_ialpha;
               ibeta_out  <= sh_ibeta;
               valpha_out <= sh_valpha;
               vbeta_out  <= sh_vbeta;
            end
            default: ;
         endcase
      end
   end

   assign bus.sample_ready = (state == ACC);
   assign bus.ialpham      = ialpha_out;
   assign bus.ibetam       = ibeta_out;
   assign bus.valpha       = valpha_out;
   assign bus.vbeta        = vbeta_out;
   assign bus.out_valid    = valid_out;
   assign bus.overrun      = overrun_flag;

endmodule

`default_nettype wire

// File: tb/tb_clarke_sampler.sv
// ============================================================================
//  tb_clarke_sampler
//  Directed self-checking bench for clarke_sampler (N=32, Q=18, AVG_LOG2=2).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clarke_sampler;

   localparam int N = 32;

   logic clk = 1'b0;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   clarke_sampler_if #(.N(N)) bus ();

   clarke_sampler #(.N(N), .Q(18), .AVG_LOG2(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic drive(input logic signed [N-1:0] a_ia, a_ib, a_ic,
                        input logic signed [N-1:0] a_va, a_vb, a_vc);
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.ia = a_ia; bus.ib = a_ib; bus.ic = a_ic;
      bus.va = a_va; bus.vb = a_vb; bus.vc = a_vc;
   endtask

   // Returns the number of edges from the last accepted sample to out_valid, or -1.
   task automatic wait_out(output int lat);
      @(negedge clk);
      bus.sample_valid = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset;
      int lat;
      reset = 1'b0;
      bus.sample_valid = 1'b1;
      bus.ia = $urandom; bus.ib = $urandom; bus.ic = $urandom;
      bus.va = $urandom; bus.vb = $urandom; bus.vc = $urandom;
      repeat (3) @(negedge clk);
      vectors++; if (bus.ialpham !== 32'sd0 || bus.ibetam !== 32'sd0 || bus.valpha !== 32'sd0 || bus.vbeta !== 32'sd0) begin
         miscompares++; $display("FAIL reset_outputs: got %0d %0d %0d %0d expected 0 0 0 0", bus.ialpham, bus.ibetam, bus.valpha, bus.vbeta);
      end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
      vectors++; if (bus.sample_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", bus.sample_ready); end
      bus.sample_valid = 1'b0;
      reset = 1'b1;
      repeat (4) drive(0, 0, 0, 0, 0, 0);
      wait_out(lat);
      vectors++; if (lat !== 6) begin miscompares++; $display("FAIL zero_latency: got %0d expected 6", lat); end
      vectors++; if (bus.ialpham !== 32'sd0 || bus.ibetam !== 32'sd0 || bus.valpha !== 32'sd0 || bus.vbeta !== 32'sd0) begin
         miscompares++; $display("FAIL zero_outputs: got %0d %0d %0d %0d expected 0 0 0 0", bus.ialpham, bus.ibetam, bus.valpha, bus.vbeta);
      end
   endtask

   task automatic test_alpha;
      int lat;
      repeat (4) drive(262144, -131072, -131072, 262144, -131072, -131072);
      wait_out(lat);
      vectors++; if (lat !== 6) begin miscompares++; $display("FAIL alpha_latency: got %0d expected 6", lat); end
      vectors++; if (bus.ialpham !== 32'sd262144 || bus.valpha !== 32'sd262144) begin
         miscompares++; $display("FAIL alpha_alpha: got %0d %0d expected 262144 262144", bus.ialpham, bus.valpha);
      end
      vectors++; if (bus.ibetam !== 32'sd0 || bus.vbeta !== 32'sd0) begin
         miscompares++; $display("FAIL alpha_beta: got %0d %0d expected 0 0", bus.ibetam, bus.vbeta);
      end
      @(negedge clk);
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL alpha_strobe_len: got %b expected 0", bus.out_valid); end
      vectors++; if (bus.ialpham !== 32'sd262144) begin miscompares++; $display("FAIL alpha_hold: got %0d expected 262144", bus.ialpham); end
   endtask

   task automatic test_beta;
      int lat;
      repeat (4) drive(0, 131072, -131072, 0, 131072, -131072);
      wait_out(lat);
      vectors++; if (lat !== 6) begin miscompares++; $display("FAIL beta_latency: got %0d expected 6", lat); end
      vectors++; if (bus.ialpham !== 32'sd0 || bus.ibetam !== 32'sd151349) begin
         miscompares++; $display("FAIL beta_current: got %0d %0d expected 0 151349", bus.ialpham, bus.ibetam);
      end
      vectors++; if (bus.valpha !== 32'sd0 || bus.vbeta !== 32'sd151349) begin
         miscompares++; $display("FAIL beta_voltage: got %0d %0d expected 0 151349", bus.valpha, bus.vbeta);
      end
   endtask

   task automatic test_mixed_paths;
      int lat;
      repeat (4) drive(0, 131072, -131072, 262144, -131072, -131072);
      wait_out(lat);
      vectors++; if (bus.ialpham !== 32'sd0 || bus.ibetam !== 32'sd151349 || bus.valpha !== 32'sd262144 || bus.vbeta !== 32'sd0) begin
         miscompares++; $display("FAIL mixed_paths: got %0d %0d %0d %0d expected 0 151349 262144 0", bus.ialpham, bus.ibetam, bus.valpha, bus.vbeta);
      end
   endtask

   task automatic test_avg_floor;
      int lat;
      drive(4, 0, 0, 4, 0, 0);
      drive(8, 0, 0, 8, 0, 0);
      drive(12, 0, 0, 12, 0, 0);
      drive(16, 0, 0, 16, 0, 0);
      wait_out(lat);
      vectors++; if (bus.ialpham !== 32'sd6 || bus.valpha !== 32'sd6) begin
         miscompares++; $display("FAIL avg_positive: got %0d %0d expected 6 6", bus.ialpham, bus.valpha);
      end
      drive(-4, 0, 0, -4, 0, 0);
      drive(-8, 0, 0, -8, 0, 0);
      drive(-12, 0, 0, -12, 0, 0);
      drive(-16, 0, 0, -16, 0, 0);
      wait_out(lat);
      vectors++; if (bus.ialpham !== -32'sd7 || bus.valpha !== -32'sd7) begin
         miscompares++; $display("FAIL avg_negative_floor: got %0d %0d expected -7 -7", bus.ialpham, bus.valpha);
      end
      vectors++; if (bus.ibetam !== 32'sd0) begin miscompares++; $display("FAIL avg_beta: got %0d expected 0", bus.ibetam); end
   endtask

   task automatic test_back_to_back;
      int strobes = 0;
      int first   = -1;
      int last_s  = -1;
      vectors++; if (bus.overrun !== 1'b0) begin miscompares++; $display("FAIL overrun_clean: got %b expected 0", bus.overrun); end
      drive(262144, -131072, -131072, 262144, -131072, -131072);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 5) begin
            vectors++; if (bus.sample_ready !== 1'b0) begin miscompares++; $display("FAIL busy_ready: got %b expected 0", bus.sample_ready); end
         end
         if (bus.out_valid === 1'b1) begin
            strobes++;
            if (first < 0) first = i;
            last_s = i;
            vectors++; if (bus.ialpham !== 32'sd262144) begin miscompares++; $display("FAIL b2b_ialpham: got %0d expected 262144", bus.ialpham); end
         end
      end
      bus.sample_valid = 1'b0;
      vectors++; if (strobes !== 2) begin miscompares++; $display("FAIL b2b_strobes: got %0d expected 2", strobes); end
      vectors++; if (first !== 10) begin miscompares++; $display("FAIL b2b_first: got %0d expected 10", first); end
      vectors++; if (last_s - first !== 10) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected 10", last_s - first); end
      vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set: got %b expected 1", bus.overrun); end
      repeat (3) @(negedge clk);
      vectors++; if (bus.overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_sticky: got %b expected 1", bus.overrun); end
   endtask

   task automatic test_reset_mid;
      int strobes = 0;
      int lat;
      repeat (4) drive(131072, -262144, 393216, 131072, -262144, 393216);
      @(negedge clk);
      bus.sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      vectors++; if (bus.ialpham !== 32'sd0 || bus.valpha !== 32'sd0) begin
         miscompares++; $display("FAIL midreset_outputs: got %0d %0d expected 0 0", bus.ialpham, bus.valpha);
      end
      vectors++; if (bus.overrun !== 1'b0 || bus.sample_ready !== 1'b1) begin
         miscompares++; $display("FAIL midreset_flags: got overrun=%b ready=%b expected 0 1", bus.overrun, bus.sample_ready);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) strobes++;
      end
      vectors++; if (strobes !== 0) begin miscompares++; $display("FAIL midreset_no_strobe: got %0d expected 0", strobes); end
      repeat (4) drive(0, 131072, -131072, 262144, -131072, -131072);
      wait_out(lat);
      vectors++; if (lat !== 6) begin miscompares++; $display("FAIL fresh_latency: got %0d expected 6", lat); end
      vectors++; if (bus.ialpham !== 32'sd0 || bus.ibetam !== 32'sd151349 || bus.valpha !== 32'sd262144 || bus.vbeta !== 32'sd0) begin
         miscompares++; $display("FAIL fresh_batch: got %0d %0d %0d %0d expected 0 151349 262144 0", bus.ialpham, bus.ibetam, bus.valpha, bus.vbeta);
      end
   endtask

   initial begin
      reset = 1'b0;
      bus.sample_valid = 1'b0;
      bus.ia = '0; bus.ib = '0; bus.ic = '0;
      bus.va = '0; bus.vb = '0; bus.vc = '0;
      test_reset();
      test_alpha();
      test_beta();
      test_mixed_paths();
      test_avg_floor();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
